// File: rtl/vsm_result_serializer.sv
// Serializes a SIZE-lane vector-scaler result one lane per handshake.
// Define VSM_SERIALIZER_OVERLAP_EN to accept next-vector beats during SEND.
module vsm_result_serializer #(
    parameter int SIZE          = 6,
    parameter int WIDTH         = 8,
    parameter int ACCUMULATIONS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*SIZE-1:0]   vec_in,
    output logic                    acc_clear,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last
);

    localparam int SW = (ACCUMULATIONS > 1) ? $clog2(ACCUMULATIONS) : 1;
    localparam int LW = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {
        COUNT   = 2'd0,
        CAPTURE = 2'd1,
        SEND    = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [SW-1:0]                step_q, step_d;
    logic [LW-1:0]                lane_q, lane_d;
    logic [SIZE-1:0][WIDTH-1:0]   shadow_q, shadow_d;

    logic step_last;
    logic lane_last;

    assign step_last = (step_q == SW'(ACCUMULATIONS - 1));
    assign lane_last = (lane_q == LW'(SIZE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= COUNT;
            step_q   <= '0;
            lane_q   <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            lane_q   <= lane_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        lane_d    = lane_q;
        shadow_d  = shadow_q;
        in_ready  = 1'b0;
        acc_clear = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        unique case (state_q)
            COUNT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (step_last) begin
                        step_d  = '0;
                        state_d = CAPTURE;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
            CAPTURE: begin
                shadow_d  = vec_in;
                acc_clear = 1'b1;
                lane_d    = '0;
                state_d   = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = shadow_q[lane_q];
                out_last  = lane_last;
`ifdef VSM_SERIALIZER_OVERLAP_EN
                // The final beat of the next vector must wait for COUNT.
                in_ready = !step_last;
                if (in_valid && !step_last) begin
                    step_d = step_q + SW'(1);
                end
`endif
                if (out_ready) begin
                    if (lane_last) begin
                        lane_d  = '0;
                        state_d = COUNT;
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end
            default: begin
                state_d = COUNT;
            end
        endcase
    end

endmodule

// File: doc/vsm_result_serializer.md
VSM_RESULT_SERIALIZER -- requirements
Module: vsm_result_serializer

Interface
REQ-001 SHALL have parameter SIZE, default 6: number of lanes in the vector-scaler result.
REQ-002 SHALL have parameter WIDTH, default 8: bits per lane.
REQ-003 SHALL have parameter ACCUMULATIONS, default 3: accepted beats per result vector.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1: one (a,b) beat is presented to the multiplier this cycle.
REQ-007 SHALL have port in_ready  output  1: the block accepts the beat; a beat is accepted when in_valid and in_ready are both 1.
REQ-008 SHALL have port vec_in  input  WIDTH*SIZE: multiplier result vector; lane i is bits [WIDTH*i +: WIDTH].
REQ-009 SHALL have port acc_clear  output  1: one-cycle pulse telling upstream to clear its accumulators.
REQ-010 SHALL have port out_data  output  WIDTH: current serialized lane.
REQ-011 SHALL have port out_valid  output  1: out_data is valid.
REQ-012 SHALL have port out_ready  input  1: downstream accepts out_data.
REQ-013 SHALL have port out_last  output  1: high with lane SIZE-1.

Function
REQ-014 SHALL implement states COUNT, CAPTURE and SEND, with a step counter (0..ACCUMULATIONS-1) and a lane counter (0..SIZE-1).
REQ-015 In COUNT, in_ready SHALL be 1, and each accepted beat SHALL increment step.
REQ-016 An accepted beat with step==ACCUMULATIONS-1 SHALL set step to 0 and move the state to CAPTURE.
REQ-017 In CAPTURE, which lasts exactly one cycle, the block SHALL latch vec_in into a SIZE-lane shadow register, pulse acc_clear, set lane to 0 and go to SEND (one-cycle capture latency after the final beat).
REQ-018 In SEND, out_valid SHALL be 1, out_data SHALL be shadow lane[lane], and out_last SHALL be (lane==SIZE-1).
REQ-019 In SEND, when out_ready is 1, lane SHALL increment; at lane==SIZE-1, lane SHALL go to 0 and the state SHALL go to COUNT.
REQ-020 While out_valid is 1 and out_ready is 0, out_data, out_last and lane SHALL hold stable.
REQ-021 The shadow register SHALL be written only in CAPTURE; vec_in changes at any other time SHALL have no effect.
REQ-022 in_valid asserted while in_ready is 0 SHALL NOT be counted.
REQ-023 Beats SHALL be counted regardless of gaps between them; there is no timeout.
REQ-024 With SIZE==1, every accepted handshake SHALL also assert out_last.
REQ-025 In CAPTURE, in_ready SHALL be 0 in every configuration.

Reset
REQ-026 On reset assertion the block SHALL go to COUNT immediately, without waiting for a clock edge, with step=0 and lane=0.
REQ-027 During reset, outputs SHALL be: out_valid=0, out_last=0, out_data=0, acc_clear=0 and in_ready=1.
REQ-028 Reset during CAPTURE or SEND SHALL discard the pending vector; the first vector after reset SHALL start at lane 0.

Configuration
REQ-029 When macro VSM_SERIALIZER_OVERLAP_EN is defined, in SEND, in_ready SHALL be 1 while step<ACCUMULATIONS-1, so beats for the next vector are accepted during serialization.
REQ-030 With VSM_SERIALIZER_OVERLAP_EN defined and step==ACCUMULATIONS-1, in_ready SHALL be 0 in SEND, so the final beat waits for COUNT.
REQ-031 With VSM_SERIALIZER_OVERLAP_EN undefined, in_ready SHALL be 0 in SEND.

Verification
REQ-032 Reset test: assert reset mid-cycle -> out_valid=0, in_ready=1 and acc_clear=0 with no clock edge needed.
REQ-033 Basic test: 3 consecutive beats, vec_in=0x060504030201 at the capture cycle, out_ready=1 -> acc_clear pulses once; out_data is 01,02,03,04,05,06 on consecutive cycles; out_last=1 only with 06.
REQ-034 Backpressure test: out_ready=0 for 4 cycles while lane 2 is presented -> out_data=03 held stable; 04 follows the first cycle with out_ready=1.
REQ-035 Gapped beats test: beats on cycles 0, 3 and 7 -> CAPTURE on cycle 8; in_valid on cycles 8-14 is not counted.
REQ-036 Mid-send reset test: reset asserted while lane 3 is presented -> out_valid=0; the next vector 0x0C0B0A090807 serializes starting with 07.
REQ-037 Overlap test (VSM_SERIALIZER_OVERLAP_EN defined): continuous in_valid during SEND -> 2 beats accepted, the 3rd is stalled until the cycle after out_last is accepted; without the macro, 0 beats are accepted during SEND.
